// File: rtl/alu_calculadora.sv
// Arithmetic stage of the 3-digit calculator: decodes 7-seg operands, runs an iterative
// add/sub/mul/div, converts the magnitude to 6 BCD digits with fixed 32-cycle latency.
module alu_calculadora (
    input  logic        clk1kHz,
    input  logic        rst,
    input  logic        start,
    input  logic [20:0] Ssegnum1,
    input  logic [20:0] Ssegnum2,
    input  logic [6:0]  operador,
    input  logic [6:0]  signo1,
    output logic [23:0] dres,
    output logic [1:0]  signo_resultado,
    output logic        busy,
    output logic        done
);
    localparam logic [6:0] SEG_NUL  = 7'b1111111;
    localparam logic [6:0] SEG_MIN  = 7'b1111110;
    localparam logic [6:0] SEG_PLUS = 7'b1101100;
    localparam logic [6:0] SEG_MULT = 7'b1001000;
    localparam logic [6:0] SEG_DIV  = 7'b1011011;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_BCD, S_DONE} state_t;
    state_t state_reg, state_next;

    // Returns {invalid, value}; digit codes are active-low abcdefg with g in bit 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        case (code)
            7'b0000001, SEG_NUL: seg_decode = 5'd0;
            7'b1001111: seg_decode = 5'd1;
            7'b0010010: seg_decode = 5'd2;
            7'b0000110: seg_decode = 5'd3;
            7'b1001100: seg_decode = 5'd4;
            7'b0100100: seg_decode = 5'd5;
            7'b0100000: seg_decode = 5'd6;
            7'b0001111: seg_decode = 5'd7;
            7'b0000000: seg_decode = 5'd8;
            7'b0000100: seg_decode = 5'd9;
            default:    seg_decode = 5'b10000;
        endcase
    endfunction

    logic [3:0] dig1 [3];
    logic [3:0] dig2 [3];
    logic [2:0] bad1, bad2;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign {bad1[gi], dig1[gi]} = seg_decode(Ssegnum1[gi*7 +: 7]);
            assign {bad2[gi], dig2[gi]} = seg_decode(Ssegnum2[gi*7 +: 7]);
        end
    endgenerate

    logic [9:0] mag1_dec, mag2_dec;
    logic       op_ok;
    logic [1:0] op_dec;

    always_comb begin
        mag1_dec = 10'(dig1[2]) * 10'd100 + 10'(dig1[1]) * 10'd10 + 10'(dig1[0]);
        mag2_dec = 10'(dig2[2]) * 10'd100 + 10'(dig2[1]) * 10'd10 + 10'(dig2[0]);
        op_ok    = 1'b1;
        op_dec   = OP_ADD;
        case (operador)
            SEG_PLUS: op_dec = OP_ADD;
            SEG_MIN:  op_dec = OP_SUB;
            SEG_MULT: op_dec = OP_MUL;
            SEG_DIV:  op_dec = OP_DIV;
            default:  op_ok  = 1'b0;
        endcase
    end

    logic [1:0]  op_reg;
    logic        neg1_reg, err_reg, res_neg_reg, done_reg;
    logic [9:0]  mag1_reg, mag2_reg, mplier_reg, quo_reg, rem_reg;
    logic [19:0] acc_reg, mcand_reg, bin_reg;
    logic [23:0] bcd_reg, dres_reg;
    logic [1:0]  sign_reg;
    logic [4:0]  cnt_reg;

    // Add/sub is a single 12-bit two's-complement sum of the signed operands.
    logic [11:0] add_a, add_b, sum, sum_mag;
    logic [19:0] acc_next;
    logic [10:0] rem_sh, rem_sub;
    logic        rem_ge;
    logic [9:0]  quo_next;
    logic [19:0] res_mag;
    logic        div_zero;

    always_comb begin
        add_a    = neg1_reg ? (12'd0 - {2'b00, mag1_reg}) : {2'b00, mag1_reg};
        add_b    = (op_reg == OP_SUB) ? (12'd0 - {2'b00, mag2_reg}) : {2'b00, mag2_reg};
        sum      = add_a + add_b;
        sum_mag  = sum[11] ? (12'd0 - sum) : sum;
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 20'd0);
        rem_sh   = {rem_reg, quo_reg[9]};
        rem_ge   = rem_sh >= {1'b0, mag2_reg};
        rem_sub  = rem_sh - {1'b0, mag2_reg};
        quo_next = {quo_reg[8:0], rem_ge};
        div_zero = (op_reg == OP_DIV) && (mag2_reg == 10'd0);
        case (op_reg)
            OP_MUL:  res_mag = acc_next;
            OP_DIV:  res_mag = {10'd0, quo_next};
            default: res_mag = {8'd0, sum_mag};
        endcase
    end

    logic [23:0] bcd_adj;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk1kHz) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   if (cnt_reg == 5'd9) state_next = S_BCD;
            S_BCD:    if (cnt_reg == 5'd19) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == S_EXEC) || (state_reg == S_BCD) || (state_reg == S_DONE);
    end

    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            cnt_reg  <= '0;
            dres_reg <= '0;
            sign_reg <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == S_DONE);
            cnt_reg  <= '0;
            case (state_reg)
                S_DECODE: begin
                    op_reg     <= op_dec;
                    neg1_reg   <= (signo1 == SEG_MIN);
                    err_reg    <= (|bad1) || (|bad2) || !op_ok;
                    mag1_reg   <= mag1_dec;
                    mag2_reg   <= mag2_dec;
                    acc_reg    <= '0;
                    mcand_reg  <= {10'd0, mag1_dec};
                    mplier_reg <= mag2_dec;
                    quo_reg    <= mag1_dec;
                    rem_reg    <= '0;
                end
                S_EXEC: begin
                    cnt_reg    <= (cnt_reg == 5'd9) ? 5'd0 : cnt_reg + 5'd1;
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    quo_reg    <= quo_next;
                    rem_reg    <= 10'(rem_ge ? rem_sub : rem_sh);
                    // The final step's result is captured straight into the converter.
                    if (cnt_reg == 5'd9) begin
                        err_reg     <= err_reg || div_zero;
                        res_neg_reg <= (res_mag != 20'd0) &&
                                       (((op_reg == OP_ADD) || (op_reg == OP_SUB)) ? sum[11] : neg1_reg);
                        bin_reg     <= res_mag;
                        bcd_reg     <= '0;
                    end
                end
                S_BCD: begin
                    cnt_reg <= (cnt_reg == 5'd19) ? 5'd0 : cnt_reg + 5'd1;
                    bcd_reg <= 24'({bcd_adj, bin_reg[19]});
                    bin_reg <= bin_reg << 1;
                end
                S_DONE: begin
                    dres_reg <= err_reg ? 24'd0 : bcd_reg;
                    sign_reg <= err_reg ? 2'd2 : {1'b0, res_neg_reg};
                end
                default: ;
            endcase
        end
    end

    assign dres            = dres_reg;
    assign signo_resultado = sign_reg;
    assign done            = done_reg;
endmodule

// File: tb/tb_alu_calculadora.sv
// Directed-vector bench for alu_calculadora: a timeline/arithmetic model checked every cycle,
// plus literal expected results per vector.
module tb_alu_calculadora;
    localparam logic [6:0] NUL  = 7'b1111111;
    localparam logic [6:0] MIN  = 7'b1111110;
    localparam logic [6:0] PLUS = 7'b1101100;
    localparam logic [6:0] MULT = 7'b1001000;
    localparam logic [6:0] DIV  = 7'b1011011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [20:0] s1 = '0, s2 = '0;
    logic [6:0]  op = PLUS, sg = PLUS;
    logic [23:0] dres;
    logic [1:0]  signo_resultado;
    logic        busy, done;

    int tests = 0;
    int fails = 0;

    alu_calculadora dut (
        .clk1kHz(clk), .rst(rst), .start(start), .Ssegnum1(s1), .Ssegnum2(s2),
        .operador(op), .signo1(sg), .dres(dres), .signo_resultado(signo_resultado),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segc(input int d);
        case (d)
            0: segc = 7'b0000001;  1: segc = 7'b1001111;  2: segc = 7'b0010010;
            3: segc = 7'b0000110;  4: segc = 7'b1001100;  5: segc = 7'b0100100;
            6: segc = 7'b0100000;  7: segc = 7'b0001111;  8: segc = 7'b0000000;
            9: segc = 7'b0000100;  default: segc = NUL;
        endcase
    endfunction

    function automatic logic [20:0] num(input int h, input int t, input int u);
        num = {segc(h), segc(t), segc(u)};
    endfunction

    function automatic int digval(input logic [6:0] c);
        digval = -1;
        if (c == NUL) digval = 0;
        for (int d = 0; d < 10; d++) if (c == segc(d)) digval = d;
    endfunction

    // Reference result {sign, dres} from plain integer arithmetic.
    function automatic logic [25:0] model(input logic [20:0] a, input logic [20:0] b,
                                          input logic [6:0] o, input logic [6:0] s);
        int m1 = 0, m2 = 0, v1, r = 0, mag, da, db;
        bit err = 0;
        logic [23:0] bcd = '0;
        for (int i = 2; i >= 0; i--) begin
            da = digval(a[i*7 +: 7]);
            db = digval(b[i*7 +: 7]);
            if (da < 0 || db < 0) err = 1;
            m1 = m1 * 10 + (da < 0 ? 0 : da);
            m2 = m2 * 10 + (db < 0 ? 0 : db);
        end
        v1 = (s == MIN) ? -m1 : m1;
        if (o == PLUS) r = v1 + m2;
        else if (o == MIN) r = v1 - m2;
        else if (o == MULT) r = v1 * m2;
        else if (o == DIV) begin
            if (m2 == 0) err = 1;
            else r = (v1 < 0) ? -(m1 / m2) : m1 / m2;
        end else err = 1;
        if (err) return {2'd2, 24'd0};
        mag = (r < 0) ? -r : r;
        for (int i = 0; i < 6; i++) begin
            bcd[i*4 +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {(r < 0) ? 2'd1 : 2'd0, bcd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Timeline model: phase counts edges since the accepting edge.
    bit          active = 0, check_en = 0;
    int          phase = 0;
    logic [25:0] pending = '0;
    logic [23:0] exp_dres = '0;
    logic [1:0]  exp_sign = '0;
    logic        exp_done = 0, exp_busy = 0;

    initial forever begin
        @(posedge clk);
        exp_done = 0;
        if (rst) begin
            active = 0; phase = 0; exp_dres = '0; exp_sign = '0;
        end else if (!active) begin
            if (start) begin active = 1; phase = 0; end
        end else begin
            phase++;
            if (phase == 1) pending = model(s1, s2, op, sg);
            if (phase == 32) begin
                active = 0; exp_done = 1;
                exp_dres = pending[23:0]; exp_sign = pending[25:24];
            end
        end
        exp_busy = active && phase >= 1;
    end

    initial begin
        wait (check_en);
        forever begin
            @(negedge clk);
            chk("cyc_busy", 32'(busy), 32'(exp_busy));
            chk("cyc_done", 32'(done), 32'(exp_done));
            chk("cyc_dres", 32'(dres), 32'(exp_dres));
            chk("cyc_sign", 32'(signo_resultado), 32'(exp_sign));
        end
    end

    typedef struct {
        string       name;
        logic [20:0] a, b;
        logic [6:0]  o, s;
        logic [23:0] d;
        logic [1:0]  sgn;
    } vec_t;

    task automatic launch(input vec_t v);
        @(negedge clk);
        s1 = v.a; s2 = v.b; op = v.o; sg = v.s; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Waits for done (bounded), returning edges since acceptance and busy cycles seen.
    task automatic wait_done(output int n, output int nbusy);
        n = 0; nbusy = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int n, nb;
        chk({v.name, "_model"}, 32'(model(v.a, v.b, v.o, v.s)), 32'({v.sgn, v.d}));
        launch(v);
        wait_done(n, nb);
        chk({v.name, "_latency"}, n, 32);
        chk({v.name, "_busycycles"}, nb, 31);
        chk({v.name, "_dres"}, 32'(dres), 32'(v.d));
        chk({v.name, "_sign"}, 32'(signo_resultado), 32'(v.sgn));
        $display("[TB] %s: dres=%h sign=%0d latency=%0d", v.name, dres, signo_resultado, n);
    endtask

    vec_t vecs[10];

    initial begin
        int n, nb, ndone;
        vec_t v;
        vecs[0] = '{"add_123_456",   num(1,2,3),   num(4,5,6),   PLUS, PLUS, 24'h000579, 2'd0};
        vecs[1] = '{"mul_m5_12",     num(-1,-1,5), num(-1,1,2),  MULT, MIN,  24'h000060, 2'd1};
        vecs[2] = '{"mul_999_999",   num(9,9,9),   num(9,9,9),   MULT, PLUS, 24'h998001, 2'd0};
        vecs[3] = '{"sub_5_12",      num(-1,-1,5), num(-1,1,2),  MIN,  PLUS, 24'h000007, 2'd1};
        vecs[4] = '{"add_m3_3",      num(-1,-1,3), num(-1,-1,3), PLUS, MIN,  24'h000000, 2'd0};
        vecs[5] = '{"sub_m999_999",  num(9,9,9),   num(9,9,9),   MIN,  MIN,  24'h001998, 2'd1};
        vecs[6] = '{"div_m7_2",      num(-1,-1,7), num(-1,-1,2), DIV,  MIN,  24'h000003, 2'd1};
        vecs[7] = '{"div_7_0",       num(-1,-1,7), num(-1,-1,0), DIV,  PLUS, 24'h000000, 2'd2};
        vecs[8] = '{"bad_digit",     num(-1,-1,7), {NUL, 7'b0110001, segc(1)}, PLUS, PLUS, 24'h000000, 2'd2};
        vecs[9] = '{"bad_operator",  num(-1,-1,7), num(-1,-1,1), NUL,  PLUS, 24'h000000, 2'd2};

        repeat (3) @(negedge clk);
        rst = 0;
        check_en = 1;
        @(negedge clk);
        chk("reset_dres", 32'(dres), 32'd0);
        chk("reset_sign", 32'(signo_resultado), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Second start ten cycles in must not produce a second done.
        launch(vecs[2]);
        repeat (9) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        ndone = 0;
        repeat (60) begin @(negedge clk); if (done) ndone++; end
        chk("restart_ignored_dones", ndone, 1);
        chk("restart_ignored_dres", 32'(dres), 32'h998001);
        $display("[TB] restart_ignored: dones=%0d dres=%h", ndone, dres);

        // Inputs changed after decode must not influence the result.
        launch(vecs[0]);
        repeat (3) @(negedge clk);
        s1 = num(9,9,9); s2 = num(9,9,9); op = MULT; sg = MIN;
        wait_done(n, nb);
        chk("late_inputs_dres", 32'(dres), 32'h000579);
        chk("late_inputs_sign", 32'(signo_resultado), 32'd0);
        $display("[TB] late_inputs: dres=%h sign=%0d", dres, signo_resultado);

        // Reset mid-operation aborts with no done.
        launch(vecs[5]);
        repeat (14) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_dres", 32'(dres), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 0;
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("abort_no_done", ndone, 0);
        $display("[TB] abort: dones=%0d dres=%h", ndone, dres);

        v = vecs[6];
        v.name = "after_abort_div";
        run_op(v);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
